// File: rtl/cache_req_sync_fifo.sv
// Clocked FIFO behind the 3-way cache-request merge: synchronizes the merge's drive pulse,
// stores its payload, acknowledges with a one-cycle free pulse, and serves a valid/ready consumer.
module cache_req_sync_fifo #(
    parameter int unsigned DATA_W      = 3,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_drive,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_free,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_data,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_overrun
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;
    logic                   r_pending;
    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_free;
    logic                   r_overrun;

    logic w_drive_edge;
    logic w_wr;
    logic w_rd;

    // Full is the registered occupancy, so a same-cycle pop never makes room for a write.
    assign o_full    = (r_count == FULL_CNT);
    assign o_valid   = (r_count != '0);
    assign o_data    = r_mem[r_rptr];
    assign o_count   = r_count;
    assign o_free    = r_free;
    assign o_overrun = r_overrun;

    always_comb begin
        w_drive_edge = r_sync[SYNC_STAGES-1] & ~r_edge;
        w_wr         = (w_drive_edge | r_pending) & ~o_full;
        w_rd         = o_valid & i_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync    <= '0;
            r_edge    <= 1'b0;
            r_pending <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_free    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_drive};
            r_edge <= r_sync[SYNC_STAGES-1];
            r_free <= w_wr;

            if (w_wr) begin
                r_pending <= 1'b0;
            end else if (w_drive_edge) begin
                r_pending <= 1'b1;
            end

            // A second request arriving while one is still parked is dropped and flagged.
            if (w_drive_edge && r_pending) begin
                r_overrun <= 1'b1;
            end

            if (w_wr) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end

            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_req_sync_fifo.sv
// Self-checking bench for cache_req_sync_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized merge traffic.
module tb_cache_req_sync_fifo;

    localparam int DATA_W = 3;
    localparam int DEPTH  = 4;
    localparam int SYNC   = 2;

    logic              clk;
    logic              rst;
    logic              i_drive;
    logic [DATA_W-1:0] i_data;
    logic              o_free;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              i_ready;
    logic [2:0]        o_count;
    logic              o_full;
    logic              o_overrun;

    cache_req_sync_fifo #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_drive   (i_drive),
        .i_data    (i_data),
        .o_free    (o_free),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .i_ready   (i_ready),
        .o_count   (o_count),
        .o_full    (o_full),
        .o_overrun (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_q[$];
    logic [SYNC:0] m_hist;
    bit          m_pend;
    bit          m_ovr;
    bit          m_free;
    bit          m_live = 0;

    bit          rand_rdy = 0;
    bit          cap = 0;
    int          popped[$];
    bit          pv;
    int          pd;
    int          maxcnt;
    int          n_free_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit de, full, wr, rd;
        if (cap && pv && i_ready && rst) popped.push_back(pd);
        if (!rst) begin
            m_q.delete();
            m_hist = '0;
            m_pend = 0;
            m_ovr  = 0;
            m_free = 0;
            m_live = 1;
            return;
        end
        // Edge seen by the write logic: drive sampled SYNC edges ago is 1, one earlier was 0
        de   = m_hist[SYNC-1] && !m_hist[SYNC];
        full = (m_q.size() == DEPTH);
        wr   = (de || m_pend) && !full;
        rd   = (m_q.size() != 0) && i_ready;
        if (de && m_pend) m_ovr = 1;
        if (wr) m_pend = 0;
        else if (de) m_pend = 1;
        m_free = wr;
        if (rd) void'(m_q.pop_front());
        if (wr) m_q.push_back(int'(i_data));
        m_hist = {m_hist[SYNC-1:0], i_drive};
    endtask

    task automatic compare();
        pv = o_valid;
        pd = int'(o_data);
        if (!m_live) return;
        chk("valid", int'(o_valid), int'(m_q.size() != 0));
        if (m_q.size() != 0) chk("data", int'(o_data), m_q[0]);
        chk("count", int'(o_count), m_q.size());
        chk("full", int'(o_full), int'(m_q.size() == DEPTH));
        chk("free", int'(o_free), int'(m_free));
        chk("overrun", int'(o_overrun), int'(m_ovr));
        if (int'(o_count) > maxcnt) maxcnt = int'(o_count);
        if (o_free) n_free_seen++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_req(input int d);
        bit got = 0;
        i_data  = DATA_W'(d);
        i_drive = 1'b1;
        for (int k = 0; k < 60 && !got; k++) begin
            cycle();
            if (o_free) got = 1;
        end
        chk("free_seen", int'(got), 1);
        i_drive = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        int f0;
        rst     = 1'b0;
        i_drive = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;

        // 1: reset then a single request
        cycle();
        cycle();
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_free", int'(o_free), 0);
        chk("rst_data", int'(o_data), 0);
        rst     = 1'b1;
        i_data  = 3'b101;
        i_drive = 1'b1;
        cycle();
        chk("t1_free_e0", int'(o_free), 0);
        cycle();
        chk("t1_free_e1", int'(o_free), 0);
        cycle();
        chk("t1_free_e2", int'(o_free), 1);
        chk("t1_valid", int'(o_valid), 1);
        chk("t1_data", int'(o_data), 5);
        chk("t1_count", int'(o_count), 1);
        i_drive = 1'b0;
        i_ready = 1'b1;
        cycle();
        chk("t1_free_once", int'(o_free), 0);
        chk("t1_valid_pop", int'(o_valid), 0);
        chk("t1_count_pop", int'(o_count), 0);
        i_ready = 1'b0;
        cycle();
        cycle();

        // 2: fill to full, stalled fifth request, drain order
        f0 = n_free_seen;
        for (int d = 1; d <= 4; d++) push_req(d);
        chk("t2_count", int'(o_count), 4);
        chk("t2_full", int'(o_full), 1);
        chk("t2_frees", n_free_seen - f0, 4);
        chk("t2_model_count", m_q.size(), 4);
        f0 = n_free_seen;
        i_data  = 3'd5;
        i_drive = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        chk("t2_no_free_full", n_free_seen - f0, 0);
        i_ready = 1'b1;
        cycle();
        chk("t2_pop_count", int'(o_count), 3);
        chk("t2_pop_nofree", int'(o_free), 0);
        i_ready = 1'b0;
        cycle();
        chk("t2_late_free", int'(o_free), 1);
        chk("t2_late_count", int'(o_count), 4);
        i_drive = 1'b0;
        i_ready = 1'b1;
        for (int d = 2; d <= 5; d++) begin
            chk("t2_drain", int'(o_data), d);
            cycle();
        end
        chk("t2_empty", int'(o_count), 0);

        // 3: wrap-around with consumer always ready
        popped.delete();
        maxcnt = 0;
        cap    = 1;
        for (int i = 0; i < 10; i++) push_req(i % 8);
        cycle();
        cycle();
        cap = 0;
        chk("t3_npop", popped.size(), 10);
        for (int i = 0; i < 10 && i < popped.size(); i++) chk("t3_order", popped[i], i % 8);
        chk("t3_max_le1", int'(maxcnt <= 1), 1);
        chk("t3_no_ovr", int'(o_overrun), 0);

        // 4: write coinciding with a pop at count 2
        i_ready = 1'b0;
        cycle();
        push_req(7);
        push_req(6);
        chk("t4_count2", int'(o_count), 2);
        i_data  = 3'd3;
        i_drive = 1'b1;
        cycle();
        cycle();
        i_ready = 1'b1;
        cycle();
        chk("t4_free", int'(o_free), 1);
        chk("t4_count_same", int'(o_count), 2);
        chk("t4_head", int'(o_data), 6);
        i_drive = 1'b0;
        cycle();
        chk("t4_tail", int'(o_data), 3);
        cycle();
        chk("t4_empty", int'(o_count), 0);
        i_ready = 1'b0;
        cycle();

        // 5: overrun while full with a request pending
        for (int d = 1; d <= 4; d++) push_req(d);
        i_data  = 3'd5;
        i_drive = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        chk("t5_no_ovr_yet", int'(o_overrun), 0);
        i_drive = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        i_drive = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        chk("t5_ovr", int'(o_overrun), 1);
        chk("t5_count", int'(o_count), 4);
        i_drive = 1'b0;
        popped.delete();
        cap     = 1;
        i_ready = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
        cap = 0;
        chk("t5_npop", popped.size(), 5);
        if (popped.size() == 5) chk("t5_last", popped[4], 5);
        chk("t5_ovr_sticky", int'(o_overrun), 1);
        chk("t5_empty", int'(o_count), 0);

        // 6: reset with entries queued and a request in flight
        i_ready = 1'b0;
        for (int d = 1; d <= 3; d++) push_req(d);
        chk("t6_count3", int'(o_count), 3);
        i_data  = 3'd6;
        i_drive = 1'b1;
        cycle();
        rst     = 1'b0;
        i_drive = 1'b0;
        cycle();
        chk("t6_valid", int'(o_valid), 0);
        chk("t6_count", int'(o_count), 0);
        chk("t6_free", int'(o_free), 0);
        chk("t6_ovr", int'(o_overrun), 0);
        rst = 1'b1;
        f0  = n_free_seen;
        for (int k = 0; k < 6; k++) cycle();
        chk("t6_no_spurious_free", n_free_seen - f0, 0);
        chk("t6_still_empty", int'(o_count), 0);

        // Randomized merge traffic with a random consumer
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            push_req(int'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 3)) cycle();
        end
        rand_rdy = 0;
        i_ready  = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        chk("rand_drained", int'(o_count), 0);
        chk("rand_no_ovr", int'(o_overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_req_sync_fifo.md
Name: cache_req_sync_fifo

Overview:
- Clocked bundled-data FIFO that sits directly downstream of the three-way mutex merge of 3-bit cache requests.
- Absorbs each merged drive pulse and its data. Returns a one-cycle free pulse that re-arms the merge.
- Presents queued requests to the clocked replacement controller over a valid/ready handshake.
- Provides the buffering stage the merge requires on its output.

Parameters:
- DATA_W, 3, width of request payload (matches merge data width).
- DEPTH, 4, number of FIFO entries; must be a power of two, ≥2.
- SYNC_STAGES, 2, flops in the drive synchronizer chain; minimum 2.

Ports:
- clk  input  1  single clock for all state.
- rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
- i_drive  input  1  request pulse from the merge; asynchronous to clk; high for at least 2 clk periods.
- i_data  input  DATA_W  bundled payload; stable from i_drive rise until o_free pulse.
- o_free  output  1  one-cycle acknowledge pulse back to the merge (its i_freeNext).
- o_valid  output  1  head entry available.
- o_data  output  DATA_W  head entry payload; valid only when o_valid = 1.
- i_ready  input  1  consumer accepts head this cycle.
- o_count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_full  output  1  occupancy == DEPTH.
- o_overrun  output  1  sticky protocol error flag.

Behaviour:
- Reset (rst = 0 at a clk edge) sets:
  - sync chain, edge flop and pending flag to 0;
  - read/write pointers and count to 0;
  - o_free, o_valid, o_full and o_overrun to 0; o_data to 0.
- A reset mid-operation discards all entries and any pending request. No o_free is issued for the discarded request.
- Synchronizer:
  - i_drive passes through SYNC_STAGES flops, then one edge flop.
  - drive_edge = last sync flop & ~edge flop (combinational). It is true for exactly one cycle per i_drive rise.
- Pending flag:
  - Set on drive_edge when the write does not occur that cycle.
  - Cleared when the write occurs.
- Write condition: wr = (drive_edge | pending) & ~o_full.
  - o_full is the registered value. A same-cycle pop does not free space for a write.
  - On wr, i_data is stored at the write pointer, the pointer advances and wraps modulo DEPTH.
- o_free: registered, high in the cycle after each wr, for exactly one cycle. One o_free per accepted request.
- Latency with an empty FIFO:
  - i_drive first sampled high at edge E.
  - wr at edge E+SYNC_STAGES.
  - o_valid and o_free high in the following cycle.
- Read condition: rd = o_valid & i_ready. Pops the head; the read pointer advances and wraps.
- o_valid = (count ≠ 0). o_data = memory at the read pointer, combinational from registered state.
- Count update:
  - +1 on wr only; −1 on rd only.
  - Unchanged on simultaneous wr and rd. Simultaneous wr and rd when count = 0 cannot occur, since o_valid = 0.
- When full:
  - The request stays pending and o_free is withheld.
  - The merge therefore stalls with no data loss.
  - The write occurs in the first cycle in which the registered o_full is 0.
- Overrun: a new drive_edge while pending = 1 sets o_overrun, which stays set until reset. The new edge is not queued separately.
- i_ready with o_valid = 0 has no effect.

Test Plan:
1. Reset, then a single request: rst low 2 cycles; i_data = 3'b101, i_drive high 3 cycles. Required: o_free high exactly 1 cycle, 3 cycles after first sample; o_valid = 1, o_data = 101, o_count = 1; with i_ready = 1, o_valid = 0 and o_count = 0 next cycle.
2. Fill to full: 4 requests with data 1, 2, 3, 4 and i_ready = 0. Required: o_count = 4, o_full = 1, four o_free pulses. Then a 5th request (data 5): no o_free while full. Raise i_ready for 1 cycle: head 1 popped; next cycle data 5 is written and o_free pulses; drain order is 2, 3, 4, 5.
3. Wrap-around: 10 requests (data 0..7, 0, 1) with i_ready held high. Required: output sequence identical to input; o_count never exceeds 1; no overrun.
4. Simultaneous push/pop: count = 2, write coincides with rd. Required: count stays 2 and the FIFO order is preserved.
5. Overrun: FIFO full with one request pending; a second i_drive rise is issued. Required: o_overrun = 1 and stays 1 after draining; only one extra entry is queued.
6. Reset mid-operation: count = 3 with a request pending; assert rst. Required: next cycle o_valid = 0, o_count = 0, o_free = 0, o_overrun = 0; no spurious o_free after rst deasserts.
